// File: rtl/dmem_unit.sv
// Data-memory unit: single-port word array fronted by a one-entry coalescing store buffer.
// Loads return data one cycle later, with bytes forwarded from the buffer.
module dmem_unit #(
    parameter int ADDR_BITS = 6
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic        ByteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataW,
    output logic        BufValid,
    output logic        AlignErr
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem [DEPTH];

    logic                 buf_valid;
    logic [ADDR_BITS-1:0] buf_addr;
    logic [31:0]          buf_data;
    logic [3:0]           buf_mask;
    logic [31:0]          read_data;
    logic                 align_err;

    logic [1:0]           lane;
    logic [ADDR_BITS-1:0] widx;
    logic                 misaligned;
    logic                 is_load;
    logic                 is_store;
    logic                 coalesce;
    logic                 drain;
    logic                 hit;
    logic [3:0]           st_mask;
    logic [31:0]          st_data;
    logic [31:0]          coal_data;
    logic [31:0]          merged;
    logic [31:0]          ld_result;
    logic                 unused_addr_bits;

    assign lane             = ALUOutM[1:0];
    assign widx             = ALUOutM[ADDR_BITS+1:2];
    assign unused_addr_bits = ^ALUOutM[31:ADDR_BITS+2];

    // Misaligned word accesses are dropped and behave like an idle cycle.
    assign misaligned = MemReqM && !ByteM && (lane != 2'b00);
    assign is_load    = MemReqM && !misaligned && !MemWriteM;
    assign is_store   = MemReqM && !misaligned && MemWriteM;
    assign hit        = buf_valid && (buf_addr == widx);
    assign coalesce   = is_store && hit;
    assign drain      = buf_valid && !is_load && !coalesce;

    assign st_mask = ByteM ? (4'b0001 << lane) : 4'b1111;
    assign st_data = ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;

    always_comb begin
        coal_data = buf_data;
        merged    = mem[widx];
        for (int i = 0; i < 4; i++) begin
            if (st_mask[i])
                coal_data[8*i +: 8] = st_data[8*i +: 8];
            if (hit && buf_mask[i])
                merged[8*i +: 8] = buf_data[8*i +: 8];
        end
        ld_result = ByteM ? {24'h0, merged[{lane, 3'b000} +: 8]} : merged;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            read_data <= '0;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_mask  <= '0;
            align_err <= 1'b0;
        end else begin
            if (misaligned)
                align_err <= 1'b1;
            if (is_load)
                read_data <= ld_result;
            if (coalesce) begin
                buf_data <= coal_data;
                buf_mask <= buf_mask | st_mask;
            end else if (is_store) begin
                buf_valid <= 1'b1;
                buf_addr  <= widx;
                buf_data  <= st_data;
                buf_mask  <= st_mask;
            end else if (drain) begin
                buf_valid <= 1'b0;
                buf_mask  <= '0;
            end
        end
    end

    // NOTE: the array has no reset; clearing a RAM costs a write port per word and buys nothing.
    always_ff @(posedge CLOCK_50) begin
        if (drain) begin
            for (int i = 0; i < 4; i++) begin
                if (buf_mask[i])
                    mem[buf_addr][8*i +: 8] <= buf_data[8*i +: 8];
            end
        end
    end

    assign ReadDataW = read_data;
    assign BufValid  = buf_valid;
    assign AlignErr  = align_err;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed self-checking bench for dmem_unit: forwarding, coalescing, drains,
// misalignment, async reset and address aliasing.
module tb_dmem_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic        by;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        buf_valid;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_unit #(.ADDR_BITS(6)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .MemReqM    (req),
        .MemWriteM  (wr),
        .ByteM      (by),
        .ALUOutM    (addr),
        .WriteDataM (wdata),
        .ReadDataW  (rdata),
        .BufValid   (buf_valid),
        .AlignErr   (align_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic w, input logic b,
                        input logic [31:0] a, input logic [31:0] d);
        req = r; wr = w; by = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);  step(1, 1, 0, a, d);  endtask
    task automatic stb(input logic [31:0] a, input logic [31:0] d); step(1, 1, 1, a, d);  endtask
    task automatic ld(input logic [31:0] a);                        step(1, 0, 0, a, 0);  endtask
    task automatic ldb(input logic [31:0] a);                       step(1, 0, 1, a, 0);  endtask
    task automatic idle();                                          step(0, 0, 0, 0, 0);  endtask

    initial begin
        rst_n = 1'b0;
        req = 0; wr = 0; by = 0; addr = 0; wdata = 0;
        #12;
        check("reset_rdata", rdata, 32'h0);
        check("reset_bufvalid", {31'h0, buf_valid}, 32'h0);
        check("reset_alignerr", {31'h0, align_err}, 32'h0);
        #4 rst_n = 1'b1;
        @(negedge clk);

        // Store then load the same word: forwarding, then array read after drain.
        st(32'h08, 32'h12345678);
        check("st08_bufvalid", {31'h0, buf_valid}, 32'h1);
        ld(32'h08);
        check("ld08_fwd", rdata, 32'h12345678);
        check("ld08_bufvalid_held", {31'h0, buf_valid}, 32'h1);
        idle();
        check("idle_drain_bufvalid", {31'h0, buf_valid}, 32'h0);
        ld(32'h08);
        check("ld08_array", rdata, 32'h12345678);

        // Word store coalesced with a byte store.
        st(32'h10, 32'hAABBCCDD);
        stb(32'h11, 32'h000000EE);
        check("coal_bufvalid", {31'h0, buf_valid}, 32'h1);
        ld(32'h10);
        check("coal_ld10", rdata, 32'hAABBEEDD);
        ldb(32'h13);
        check("coal_ldb13", rdata, 32'h000000AA);
        idle();
        ld(32'h10);
        check("coal_ld10_array", rdata, 32'hAABBEEDD);

        // Back-to-back stores to different words drain and refill on one edge.
        st(32'h04, 32'h1);
        st(32'h08, 32'h2);
        check("run_bufvalid_1", {31'h0, buf_valid}, 32'h1);
        st(32'h0C, 32'h3);
        check("run_bufvalid_2", {31'h0, buf_valid}, 32'h1);
        idle();
        check("run_drained", {31'h0, buf_valid}, 32'h0);
        ld(32'h04);
        check("run_ld04", rdata, 32'h1);
        ld(32'h08);
        check("run_ld08", rdata, 32'h2);
        ld(32'h0C);
        check("run_ld0c", rdata, 32'h3);

        // Load stream holds a buffered store; forwarding keeps results right.
        st(32'h30, 32'hCAFEF00D);
        ld(32'h08);
        check("hold_ld08", rdata, 32'h2);
        check("hold_bufvalid", {31'h0, buf_valid}, 32'h1);
        ld(32'h30);
        check("hold_ld30", rdata, 32'hCAFEF00D);
        idle();

        // Misaligned accesses: sticky error, dropped load and store.
        st(32'h00, 32'h0);
        idle();
        ld(32'h06);
        check("mis_ld_alignerr", {31'h0, align_err}, 32'h1);
        check("mis_ld_rdata_held", rdata, 32'hCAFEF00D);
        st(32'h02, 32'hFF);
        check("mis_st_bufvalid", {31'h0, buf_valid}, 32'h0);
        idle();
        ld(32'h00);
        check("mis_st_word0", rdata, 32'h0);
        check("mis_alignerr_sticky", {31'h0, align_err}, 32'h1);

        // Pending store is discarded by an asynchronous reset.
        st(32'h20, 32'h0);
        idle();
        ld(32'h10);
        st(32'h20, 32'hDEADBEEF);
        req = 0; wr = 0; by = 0; addr = 0; wdata = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rdata", rdata, 32'h0);
        check("async_bufvalid", {31'h0, buf_valid}, 32'h0);
        check("async_alignerr", {31'h0, align_err}, 32'h0);
        #1 rst_n = 1'b1;
        ld(32'h10);
        check("post_reset_ld10", rdata, 32'hAABBEEDD);
        ld(32'h20);
        check("post_reset_ld20", rdata, 32'h0);

        // Address aliasing: 0x100 maps to word 0.
        stb(32'h100, 32'h55);
        idle();
        ld(32'h000);
        check("alias_ld000", rdata, 32'h00000055);
        ldb(32'h101);
        check("alias_ldb101", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
